// File: rtl/assumer4_pkg.sv
// Shared types and default parameters for the assumer4 handshake controller.
package assumer4_pkg;

  localparam int LEN_W_DEFAULT    = 8;
  localparam int WD_LIMIT_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    SETR,
    DONE,
    ERR
  } stateT;

endpackage

// File: rtl/assumer4_counter.sv
// Loadable down-counter holding the remaining RUN length, with a zero flag.
module assumer4_counter
  import assumer4_pkg::*;
#(
  parameter int W = LEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/assumer4_controller.sv
// Four-phase request/acknowledge controller that starts a datapath, times a
// RUN phase of programmable length, and flags a missing start echo.
module assumer4_controller
  import assumer4_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEFAULT,
  parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqAR4,
  input  logic [LEN_W-1:0] lenAR4,
  input  logic             beginAR4,
  output logic             startAR4,
  output logic             setRAR4,
  output logic             ackAR4,
  output logic             busyAR4,
  output logic             errAR4,
  output logic [LEN_W-1:0] cntAR4
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  stateT            state;
  stateT            nextState;
  logic [WD_W-1:0]  wdCnt;
  logic             cntLoad;
  logic             cntDec;
  logic [LEN_W-1:0] cntLoadVal;
  logic             cntZero;

  assumer4_counter #(
    .W(LEN_W)
  ) runCounter (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .loadVal(cntLoadVal),
    .dec    (cntDec),
    .count  (cntAR4),
    .zero   (cntZero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    nextState  = state;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqAR4) begin
          nextState  = START;
          cntLoad    = 1'b1;
          cntLoadVal = lenAR4;
        end
      end
      START: begin
        if (beginAR4) begin
          nextState = cntZero ? SETR : RUN;
        end else if (wdCnt == WD_W'(WD_LIMIT - 1)) begin
          // Loading zero keeps the visible count at 0 while in ERR.
          nextState = ERR;
          cntLoad   = 1'b1;
        end
      end
      RUN: begin
        cntDec = 1'b1;
        if (cntAR4 == LEN_W'(1)) nextState = SETR;
      end
      SETR: nextState = DONE;
      DONE: if (!reqAR4) nextState = IDLE;
      ERR:  if (!reqAR4) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and never see a combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wdCnt    <= '0;
      startAR4 <= 1'b0;
      setRAR4  <= 1'b0;
      ackAR4   <= 1'b0;
      busyAR4  <= 1'b0;
      errAR4   <= 1'b0;
    end else begin
      state <= nextState;
      if (state != START) begin
        wdCnt <= '0;
      end else if (!beginAR4) begin
        wdCnt <= wdCnt + WD_W'(1);
      end
      startAR4 <= (nextState == START) || (nextState == RUN);
      setRAR4  <= (nextState == SETR);
      ackAR4   <= (nextState == DONE);
      busyAR4  <= (nextState != IDLE);
      errAR4   <= (nextState == ERR);
    end
  end

endmodule

// File: tb/tb_assumer4_controller.sv
// Scoreboard bench for assumer4_controller: each scenario queues per-cycle
// stimulus with the output vector expected after that clock edge.
module tb_assumer4_controller;
  import assumer4_pkg::*;

  localparam int LW = LEN_W_DEFAULT;

  typedef struct packed {
    logic          rst;
    logic          req;
    logic [LW-1:0] len;
  } stimT;

  // {startAR4, setRAR4, ackAR4, busyAR4, errAR4, cntAR4}
  typedef logic [LW+4:0] obsT;

  logic          clk;
  logic          rst;
  logic          reqAR4;
  logic [LW-1:0] lenAR4;
  logic          beginAR4;
  logic          startAR4;
  logic          setRAR4;
  logic          ackAR4;
  logic          busyAR4;
  logic          errAR4;
  logic [LW-1:0] cntAR4;
  logic          echoEn;

  stimT stimQ[$];
  obsT  expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  assumer4_controller dut (
    .clk     (clk),
    .rst     (rst),
    .reqAR4  (reqAR4),
    .lenAR4  (lenAR4),
    .beginAR4(beginAR4),
    .startAR4(startAR4),
    .setRAR4 (setRAR4),
    .ackAR4  (ackAR4),
    .busyAR4 (busyAR4),
    .errAR4  (errAR4),
    .cntAR4  (cntAR4)
  );

  // The downstream datapath echoes startAR4 back unless the echo is cut.
  assign beginAR4 = echoEn & startAR4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  function automatic obsT ex(input logic s, input logic r, input logic a,
                             input logic b, input logic e, input logic [LW-1:0] c);
    return {s, r, a, b, e, c};
  endfunction

  function automatic obsT expIdle();                      return ex(0, 0, 0, 0, 0, '0); endfunction
  function automatic obsT expStart(input logic [LW-1:0] c); return ex(1, 0, 0, 1, 0, c);  endfunction
  function automatic obsT expSetR();                      return ex(0, 1, 0, 1, 0, '0); endfunction
  function automatic obsT expDone();                      return ex(0, 0, 1, 1, 0, '0); endfunction
  function automatic obsT expErr();                       return ex(0, 0, 0, 1, 1, '0); endfunction

  task automatic stage(input logic r, input logic q, input logic [LW-1:0] ln, input obsT e);
    stimQ.push_back({r, q, ln});
    expQ.push_back(e);
  endtask

  // Drives one queued stimulus, clocks it in, and samples just after the edge.
  task automatic tick(output obsT obs);
    stimT s;
    s      = stimQ.pop_front();
    rst    = s.rst;
    reqAR4 = s.req;
    lenAR4 = s.len;
    @(posedge clk);
    #1;
    obs = {startAR4, setRAR4, ackAR4, busyAR4, errAR4, cntAR4};
  endtask

  task automatic test_reset();
    obsT obs, exp;
    int  cyc = 0;
    echoEn = 1'b1;
    stage(1, 1, 8'd7, expIdle());
    stage(1, 1, 8'd7, expIdle());
    stage(0, 0, 8'd0, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL reset cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_single_run();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd3, expStart(8'd3));
    for (int i = 3; i >= 1; i--) stage(0, 1, 8'd3, expStart(LW'(i)));
    stage(0, 1, 8'd3, expSetR());
    stage(0, 1, 8'd3, expDone());
    stage(0, 1, 8'd3, expDone());
    stage(0, 0, 8'd0, expIdle());
    stage(0, 0, 8'd0, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL single_run cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_zero_len();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd0, expStart(8'd0));
    stage(0, 1, 8'd0, expSetR());
    stage(0, 1, 8'd0, expDone());
    stage(0, 0, 8'd0, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL zero_len cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_watchdog();
    obsT obs, exp;
    int  cyc = 0;
    echoEn = 1'b0;
    for (int i = 0; i < 4; i++) stage(0, 1, 8'd5, expStart(8'd5));
    stage(0, 1, 8'd5, expErr());
    stage(0, 1, 8'd5, expErr());
    stage(0, 0, 8'd5, expIdle());
    stage(0, 0, 8'd0, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL watchdog cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
    echoEn = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd5, expStart(8'd5));
    stage(0, 1, 8'd5, expStart(8'd5));
    stage(0, 1, 8'd5, expStart(8'd4));
    stage(1, 1, 8'd5, expIdle());
    for (int i = 0; i < 6; i++) stage(0, 0, 8'd5, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL reset_mid_run cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_req_held();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd1, expStart(8'd1));
    stage(0, 1, 8'd1, expStart(8'd1));
    stage(0, 1, 8'd1, expSetR());
    for (int i = 0; i < 10; i++) stage(0, 1, 8'd1, expDone());
    stage(0, 0, 8'd1, expIdle());
    stage(0, 0, 8'd1, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL req_held cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_len_change();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd2, expStart(8'd2));
    stage(0, 1, 8'd9, expStart(8'd2));
    stage(0, 1, 8'd9, expStart(8'd1));
    stage(0, 0, 8'd9, expSetR());
    stage(0, 0, 8'd9, expDone());
    stage(0, 0, 8'd9, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL len_change cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_req_drop();
    obsT obs, exp;
    int  cyc = 0;
    stage(0, 1, 8'd3, expStart(8'd3));
    stage(0, 0, 8'd3, expStart(8'd3));
    stage(0, 0, 8'd3, expStart(8'd2));
    stage(0, 0, 8'd3, expStart(8'd1));
    stage(0, 0, 8'd3, expSetR());
    stage(0, 0, 8'd3, expDone());
    stage(0, 0, 8'd3, expIdle());
    while (stimQ.size() > 0) begin
      tick(obs);
      exp = expQ.pop_front();
      testsRun++;
      cyc++;
      if (obs !== exp) begin
        testsFailed++;
        $display("FAIL req_drop cycle %0d: got %b expected %b", cyc, obs, exp);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    reqAR4 = 1'b0;
    lenAR4 = '0;
    echoEn = 1'b1;
    test_reset();
    test_single_run();
    test_zero_len();
    test_watchdog();
    test_reset_mid_run();
    test_req_held();
    test_len_change();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
